cnn_flatten_buffer: RTL and testbench
=====================================

# cnn_flatten_buffer

Collects the pooled feature-map stream, one 22-bit signed pixel per accepted beat, into a 225-entry flattened vector. It drives the fully connected layer's parallel data input and its level-sensitive start handshake, then captures the 48-bit FC result and re-arms for the next frame. The block sits between the last pooling stage and the FC layer and is the producer side of the FC layer's start/result interface.

## Interface
- `DATA_W`, default 22: signed element width.
- `NUM_ELEM`, default 225: elements per frame (15×15).
- `ACC_W`, default 48: width of the FC result.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `i_valid` input, 1 bit: pixel beat valid.
- `i_sof` input, 1 bit: first pixel of a frame; qualified by `i_valid`.
- `i_data` input, signed `DATA_W`: pixel value.
- `o_ready` output, 1 bit: buffer accepts a beat.
- `o_flattened_data` output, signed `DATA_W` × [0:NUM_ELEM-1]: the FC data vector.
- `o_fc_start` output, 1 bit: level start to the FC layer.
- `i_fc_result_valid` input, 1 bit: FC result valid, a level held by the FC.
- `i_fc_result_data` input, signed `ACC_W`: FC result.
- `o_result_valid` output, 1 bit: one-cycle pulse when the result is captured.
- `o_result_data` output, signed `ACC_W`: captured result, held.
- `o_frame_count` output, 16 bits: completed frames, wraps at 65535→0.

## Operation
- States: COLLECT, START, RELEASE.
- Reset: state COLLECT; write index 0; all buffer entries 0; `o_fc_start`, `o_result_valid` and `o_frame_count` are 0; `o_result_data` is 0. `o_ready` is 1 from the first cycle after reset.
- `o_ready` = (state == COLLECT). A beat is accepted when `i_valid && o_ready`.
- COLLECT:
  - An accepted beat writes `buf[idx]`, then `idx++`.
  - If `i_sof` is set on an accepted beat, the beat is written to `buf[0]` and `idx` becomes 1. Any partial frame is discarded; stale entries at 1 and above remain until overwritten.
  - The beat that writes index NUM_ELEM-1 sets `idx` to 0 and moves to START.
- START:
  - `o_fc_start` = 1, and the buffer is frozen.
  - On `i_fc_result_valid` = 1: latch `o_result_data` ← `i_fc_result_data`, pulse `o_result_valid` for one cycle, increment `o_frame_count`, drop `o_fc_start`, and go to RELEASE.
- RELEASE:
  - `o_fc_start` = 0.
  - Wait for `i_fc_result_valid` = 0, then go to COLLECT.
  - This guarantees the FC sees a low start before the next rising edge, which it needs for edge detection.
- Beats presented while `o_ready` = 0 are not consumed. The upstream block holds them.
- `i_fc_result_valid` seen in COLLECT is ignored.
- `o_flattened_data` is driven directly from the buffer registers; there is no extra output stage.
- Reset asserted mid-frame or mid-handshake returns everything to the reset values on the next edge. `o_fc_start` falls on that edge.

## Timing
- Last beat accepted at edge N: state is START and `o_fc_start` = 1 after edge N. `o_ready` = 0 in the same cycle.
- `i_fc_result_valid` sampled high at edge M:
  - `o_result_valid` = 1 and `o_result_data` is valid for exactly one cycle after M.
  - `o_fc_start` = 0 after M.
- RELEASE exit: the first edge where `i_fc_result_valid` is sampled 0. `o_ready` = 1 after that edge.
- Minimum gap between the last beat and the first beat of the next frame is 3 cycles, plus the FC latency.
- Throughput in COLLECT is one beat per cycle.

## Structure
- Shared package `cnn_pkg` holds:
  - `DATA_W`, `NUM_ELEM`, `ACC_W`;
  - typedef `pixel_t` (signed [DATA_W-1:0]);
  - typedef `acc_t` (signed [ACC_W-1:0]);
  - the state enum `flat_state_t`.
- One sub-module fits naturally: `flatten_wr_ctrl`. It owns the write index, the SOF resync and the last-beat flag. The top level owns the buffer and the handshake state machine.

## Test plan
- **Full frame:** stream 225 beats with values 0..224, `i_sof` on the first.
  - `o_ready` falls after beat 224 and `o_fc_start` = 1.
  - `o_flattened_data[k]` = k for all k.
- **Handshake:** in START, hold `i_fc_result_valid` = 1 with data 48'h0000_1234_5678 for 3 cycles, then drop it.
  - One `o_result_valid` pulse; `o_result_data` = 48'h0000_1234_5678.
  - `o_fc_start` drops after the first valid cycle.
  - `o_ready` returns only after valid is low.
  - `o_frame_count` = 1.
- **SOF resync:** send 100 beats, then `i_sof` with value -5 (22'h3FFFFB), then 224 more beats.
  - `buf[0]` = -5, and the frame completes on the 225th beat counted from the SOF.
- **Backpressure:** hold `i_valid` = 1 through START and RELEASE.
  - No buffer write occurs; `buf[0]` is unchanged until COLLECT resumes.
- **Reset mid-handshake:** assert `rst` for 1 cycle while in START.
  - Next cycle: `o_fc_start` = 0, `o_ready` = 1, `o_frame_count` = 0, all buffer entries 0.
- **Back-to-back frames with an FC model:** 3 frames.
  - Each result is captured once, and `o_frame_count` = 3.
  - Each `o_fc_start` rising edge is preceded by at least one low cycle.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizing for the CNN flatten stage and its FC handshake.
package cnn_pkg;

  localparam int DATA_W   = 22;
  localparam int NUM_ELEM = 225;
  localparam int ACC_W    = 48;
  localparam int IDX_W    = $clog2(NUM_ELEM);

  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_START   = 2'd1,
    ST_RELEASE = 2'd2
  } flat_state_t;

  // Completed-frame counter step; 16-bit arithmetic wraps 65535 -> 0 by itself.
  function automatic logic [15:0] frame_count_next(input logic [15:0] cnt);
    return cnt + 16'd1;
  endfunction

endpackage

// File: rtl/flatten_wr_ctrl.sv
// Write-address generator for the flatten buffer: index, SOF resync and last-beat flag.
module flatten_wr_ctrl #(
  parameter int NUM_ELEM = 225,
  parameter int IDX_W    = $clog2(NUM_ELEM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             sof,
  output logic [IDX_W-1:0] wr_addr,
  output logic             last_beat
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  logic [IDX_W-1:0] idx_r;

  // SOF forces the beat to slot 0 regardless of how far the partial frame got.
  always_comb begin
    wr_addr   = idx_r;
    last_beat = 1'b0;
    if (sof) begin
      wr_addr = {IDX_W{1'b0}};
    end else begin
      wr_addr = idx_r;
    end
    last_beat = accept && (wr_addr == LAST_IDX);
  end

  // Advance after each accepted beat; wrap to 0 once the final slot is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (accept) begin
      if (last_beat) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= wr_addr + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_flatten_buffer.sv
// Collects one pooled frame into a flat vector, starts the FC layer and captures its result.
module cnn_flatten_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W   = cnn_pkg::DATA_W,
  parameter int NUM_ELEM = cnn_pkg::NUM_ELEM,
  parameter int ACC_W    = cnn_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic                     i_sof,
  input  logic signed [DATA_W-1:0] i_data,
  output logic                     o_ready,
  output logic signed [DATA_W-1:0] o_flattened_data [0:NUM_ELEM-1],
  output logic                     o_fc_start,
  input  logic                     i_fc_result_valid,
  input  logic signed [ACC_W-1:0]  i_fc_result_data,
  output logic                     o_result_valid,
  output logic signed [ACC_W-1:0]  o_result_data,
  output logic [15:0]              o_frame_count
);

  localparam int BUF_IDX_W = $clog2(NUM_ELEM);

  flat_state_t          state_r;
  flat_state_t          state_nxt_s;
  logic                 accept_s;
  logic                 last_beat_s;
  logic                 capture_s;
  logic [BUF_IDX_W-1:0] wr_addr_s;

  assign accept_s  = i_valid && o_ready;
  assign capture_s = (state_r == ST_START) && i_fc_result_valid;

  flatten_wr_ctrl #(
    .NUM_ELEM (NUM_ELEM),
    .IDX_W    (BUF_IDX_W)
  ) u_wr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept_s),
    .sof       (i_sof),
    .wr_addr   (wr_addr_s),
    .last_beat (last_beat_s)
  );

  // RELEASE waits for the FC to drop valid so the next start is seen as a fresh edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (last_beat_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_START: begin
        if (i_fc_result_valid) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_RELEASE: begin
        if (!i_fc_result_valid) begin
          state_nxt_s = ST_COLLECT;
        end else begin
          state_nxt_s = ST_RELEASE;
        end
      end
      default: state_nxt_s = ST_COLLECT;
    endcase
  end

  // State plus its registered decodes, so ready/start never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_COLLECT;
      o_ready    <= 1'b1;
      o_fc_start <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      o_ready    <= (state_nxt_s == ST_COLLECT);
      o_fc_start <= (state_nxt_s == ST_START);
    end
  end

  // Result capture: one-cycle valid pulse, data held until the next frame's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_result_valid <= 1'b0;
      o_result_data  <= {ACC_W{1'b0}};
      o_frame_count  <= 16'd0;
    end else if (capture_s) begin
      o_result_valid <= 1'b1;
      o_result_data  <= i_fc_result_data;
      o_frame_count  <= frame_count_next(o_frame_count);
    end else begin
      o_result_valid <= 1'b0;
    end
  end

  // Buffer only moves while ready is high, which freezes it for the FC read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ELEM; k++) begin
        o_flattened_data[k] <= {DATA_W{1'b0}};
      end
    end else if (accept_s) begin
      o_flattened_data[wr_addr_s] <= i_data;
    end
  end

endmodule

// File: tb/tb_cnn_flatten_buffer.sv
// Randomized bench for cnn_flatten_buffer against a frame-level behavioural model.
module tb_cnn_flatten_buffer;
  localparam int N = 225;
  localparam int PH_COLLECT = 0;
  localparam int PH_WAIT_FC = 1;
  localparam int PH_DRAIN   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic               i_sof = 1'b0;
  logic signed [21:0] i_data = 22'sd0;
  logic               i_fc_result_valid = 1'b0;
  logic signed [47:0] i_fc_result_data = 48'sd0;
  logic               o_ready;
  logic signed [21:0] o_flattened_data [0:N-1];
  logic               o_fc_start;
  logic               o_result_valid;
  logic signed [47:0] o_result_data;
  logic [15:0]        o_frame_count;

  always #5 clk = ~clk;

  cnn_flatten_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .i_valid           (i_valid),
    .i_sof             (i_sof),
    .i_data            (i_data),
    .o_ready           (o_ready),
    .o_flattened_data  (o_flattened_data),
    .o_fc_start        (o_fc_start),
    .i_fc_result_valid (i_fc_result_valid),
    .i_fc_result_data  (i_fc_result_data),
    .o_result_valid    (o_result_valid),
    .o_result_data     (o_result_data),
    .o_frame_count     (o_frame_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  int rv_pulses = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: where the next pixel lands, which phase, what result is held.
  int                 m_phase = PH_COLLECT;
  int                 m_pos = 0;
  int                 m_frames = 0;
  bit                 m_rv = 1'b0;
  logic signed [47:0] m_res = 48'sd0;
  logic signed [21:0] m_buf [0:N-1];
  bit                 beat_taken = 1'b0;

  task automatic model_step();
    beat_taken = 1'b0;
    if (rst) begin
      m_phase = PH_COLLECT; m_pos = 0; m_frames = 0; m_rv = 1'b0; m_res = 48'sd0;
      for (int k = 0; k < N; k++) m_buf[k] = 22'sd0;
    end else begin
      m_rv = 1'b0;
      if (m_phase == PH_COLLECT) begin
        if (i_valid) begin
          beat_taken = 1'b1;
          if (i_sof) m_pos = 0;
          m_buf[m_pos] = i_data;
          m_pos = m_pos + 1;
          if (m_pos == N) begin
            m_pos = 0;
            m_phase = PH_WAIT_FC;
          end
        end
      end else if (m_phase == PH_WAIT_FC) begin
        if (i_fc_result_valid) begin
          m_res = i_fc_result_data;
          m_rv = 1'b1;
          m_frames = (m_frames + 1) % 65536;
          m_phase = PH_DRAIN;
        end
      end else begin
        if (!i_fc_result_valid) m_phase = PH_COLLECT;
      end
    end
  endtask

  initial for (int k = 0; k < N; k++) m_buf[k] = 22'sd0;

  always @(posedge clk) model_step();

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      int bad_k;
      bad_k = -1;
      chk("ready", o_ready, (m_phase == PH_COLLECT));
      chk("fc_start", o_fc_start, (m_phase == PH_WAIT_FC));
      chk("result_valid", o_result_valid, m_rv);
      chk("result_data", o_result_data, m_res);
      chk("frame_count", o_frame_count, m_frames);
      for (int k = 0; k < N; k++) begin
        if (o_flattened_data[k] !== m_buf[k] && bad_k < 0) bad_k = k;
      end
      if (bad_k < 0) bad_k = 0;
      chk($sformatf("buf[%0d]", bad_k), o_flattened_data[bad_k], m_buf[bad_k]);
      if (o_result_valid === 1'b1) rv_pulses++;
    end
  end

  task automatic timeout(input string nm);
    n_bad++;
    $display("FAIL %s: got timeout expected event at %0t", nm, $time);
  endtask

  task automatic send_beat(input logic signed [21:0] d, input bit s);
    int n;
    n = 0;
    i_valid = 1'b1; i_data = d; i_sof = s;
    do begin
      @(negedge clk);
      n++;
    end while (!beat_taken && n < 200);
    if (!beat_taken) timeout("send_beat");
    i_valid = 1'b0; i_sof = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input bit noise);
    for (int k = 0; k < N; k++) begin
      i_fc_result_valid = noise && (k < 10);
      send_beat(22'($urandom), k == 0);
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
    end
    i_fc_result_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (o_fc_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (o_fc_start !== 1'b1) timeout("wait_start");
  endtask

  task automatic fc_respond(input logic signed [47:0] d, input int hold);
    int n;
    wait_start();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    i_fc_result_valid = 1'b1; i_fc_result_data = d;
    repeat (hold) @(negedge clk);
    i_fc_result_valid = 1'b0;
    n = 0;
    while (o_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_ready !== 1'b1) timeout("release_exit");
  endtask

  initial begin
    int nz;
    logic signed [47:0] last_d;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk("reset_ready", o_ready, 1'b1);
    chk("reset_count", o_frame_count, 16'd0);
    rst = 1'b0;

    // Full ramp frame.
    for (int k = 0; k < N; k++) send_beat(22'(k), k == 0);
    chk("ramp_ready_low", o_ready, 1'b0);
    chk("ramp_start_high", o_fc_start, 1'b1);
    chk("ramp_buf0", o_flattened_data[0], 22'sd0);
    chk("ramp_buf100", o_flattened_data[100], 22'sd100);
    chk("ramp_buf224", o_flattened_data[224], 22'sd224);

    // Handshake with a held upstream beat as backpressure.
    i_valid = 1'b1; i_data = 22'sd777; i_sof = 1'b1;
    @(negedge clk);
    chk("bp_buf0_start", o_flattened_data[0], 22'sd0);
    i_fc_result_valid = 1'b1; i_fc_result_data = 48'sh0000_1234_5678;
    @(negedge clk);
    chk("hs_pulse", o_result_valid, 1'b1);
    chk("hs_data", o_result_data, 48'sh0000_1234_5678);
    chk("hs_start_drop", o_fc_start, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("hs_single_pulse", o_result_valid, 1'b0);
      chk("hs_ready_held", o_ready, 1'b0);
      chk("bp_buf0_release", o_flattened_data[0], 22'sd0);
    end
    i_fc_result_valid = 1'b0;
    @(negedge clk);
    chk("hs_ready_back", o_ready, 1'b1);
    chk("hs_count", o_frame_count, 16'd1);
    @(negedge clk);
    chk("bp_resume_write", o_flattened_data[0], 22'sd777);
    i_valid = 1'b0; i_sof = 1'b0;

    // SOF resync mid-frame.
    for (int k = 0; k < 100; k++) send_beat(22'(1000 + k), 1'b0);
    send_beat(22'sh3FFFFB, 1'b1);
    for (int k = 0; k < 223; k++) send_beat(22'(2000 + k), 1'b0);
    chk("sof_not_early", o_ready, 1'b1);
    send_beat(22'sd5, 1'b0);
    chk("sof_complete", o_fc_start, 1'b1);
    chk("sof_buf0", o_flattened_data[0], 22'sh3FFFFB);
    fc_respond(48'($urandom), 2);

    // Reset while waiting for the FC.
    send_frame(1'b1, 1'b0);
    wait_start();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_start_low", o_fc_start, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_count", o_frame_count, 16'd0);
    nz = 0;
    for (int k = 0; k < N; k++) if (o_flattened_data[k] !== 22'sd0) nz++;
    chk("rst_buf_clear", nz, 0);

    // Three back-to-back frames with a randomized FC responder.
    rv_pulses = 0;
    last_d = 48'sd0;
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b1, f == 1);
      last_d = {16'($urandom), 32'($urandom)};
      fc_respond(last_d, $urandom_range(1, 3));
    end
    @(negedge clk);
    chk("b2b_count", o_frame_count, 16'd3);
    chk("b2b_pulses", rv_pulses, 3);
    chk("b2b_last_result", o_result_data, last_d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
